// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and constants for the direct-mapped L1 data
//                cache. Holds the controller state encoding, the line and
//                offset geometry, and the tag-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    localparam int LINE_W     = 128;
    localparam int WORD_SEL_W = 2;
    localparam int OFFSET_W   = 4;

    // Tag covers everything above the index and the 16-byte line offset.
    function automatic int TAG_W(input int idx_w);
        return 28 - idx_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_sram.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_sram
//  Description : Valid/dirty/tag/data storage for the direct-mapped cache.
//                Asynchronous read of the indexed line; synchronous write of
//                either a single word (store hit, sets dirty) or a full line
//                (refill, sets valid and clears dirty). Valid and dirty clear
//                asynchronously on reset; tag and data are never cleared.
//  Ports       : clk_i, rst_i (async, active-low)
//                idx_i                         - line index for read and write
//                valid_o/dirty_o/tag_o/line_o  - indexed line contents
//                word_we_i/word_data_i         - per-word store write
//                line_we_i/line_tag_i/line_data_i - full-line refill write
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 4,
    parameter int TAG_BITS   = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic                  valid_o,
    output logic                  dirty_o,
    output logic [TAG_BITS-1:0]   tag_o,
    output logic [LINE_W-1:0]     line_o,
    input  logic [LINE_WORDS-1:0] word_we_i,
    input  logic [31:0]           word_data_i,
    input  logic                  line_we_i,
    input  logic [TAG_BITS-1:0]   line_tag_i,
    input  logic [LINE_W-1:0]     line_data_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (|word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag/data carry no reset: valid gates every use of them.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[idx_i]  <= line_tag_i;
            data_q[idx_i] <= line_data_i;
        end else begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                if (word_we_i[w]) begin
                    data_q[idx_i][w*32 +: 32] <= word_data_i;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Direct-mapped, write-back, write-allocate L1 data-cache
//                controller. Hits complete combinationally; misses stall the
//                pipeline while a dirty victim is written back and the line
//                is refilled over a request/acknowledge memory port.
//  Ports       : clk_i, rst_i (async, active-low)
//                cpu_req_i/cpu_we_i/cpu_addr_i/cpu_data_i - MEM-stage access
//                cpu_data_o/cpu_stall_o                   - load data, stall
//                mem_req_o/mem_we_o/mem_addr_o/mem_data_o - line request
//                mem_data_i/mem_ack_i                     - refill, completion
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cpu_req_i,
    input  logic               cpu_we_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [31:0]        cpu_data_i,
    output logic [31:0]        cpu_data_o,
    output logic               cpu_stall_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [31:0]        mem_addr_o,
    output logic [LINE_W-1:0]  mem_data_o,
    input  logic [LINE_W-1:0]  mem_data_i,
    input  logic               mem_ack_i
);

    localparam int IDX_W    = $clog2(NUM_LINES);
    localparam int TAG_BITS = TAG_W(IDX_W);

    state_e state_q;
    state_e state_d;

    logic [TAG_BITS-1:0]   w_tag;
    logic [IDX_W-1:0]      w_idx;
    logic [WORD_SEL_W-1:0] w_word;
    logic                  w_valid;
    logic                  w_dirty;
    logic [TAG_BITS-1:0]   w_vtag;
    logic [LINE_W-1:0]     w_line;
    logic                  w_hit;
    logic                  w_idle_hit;
    logic                  w_refill;
    logic [LINE_WORDS-1:0] w_word_we;
    logic [31:0]           w_words [LINE_WORDS];
    logic                  w_unused;

    assign w_tag  = cpu_addr_i[31:OFFSET_W+IDX_W];
    assign w_idx  = cpu_addr_i[OFFSET_W+IDX_W-1:OFFSET_W];
    assign w_word = cpu_addr_i[OFFSET_W-1:2];
    // Byte offset within a word is not used: accesses are word-aligned.
    assign w_unused = &{1'b0, cpu_addr_i[1:0]};

    dcache_sram #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .TAG_BITS   (TAG_BITS)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (w_idx),
        .valid_o     (w_valid),
        .dirty_o     (w_dirty),
        .tag_o       (w_vtag),
        .line_o      (w_line),
        .word_we_i   (w_word_we),
        .word_data_i (cpu_data_i),
        .line_we_i   (w_refill),
        .line_tag_i  (w_tag),
        .line_data_i (mem_data_i)
    );

    generate
        for (genvar g = 0; g < LINE_WORDS; g++) begin : g_words
            assign w_words[g] = w_line[g*32 +: 32];
        end
    endgenerate

    assign w_hit      = cpu_req_i & w_valid & (w_vtag == w_tag);
    assign w_idle_hit = (state_q == IDLE) & w_hit;
    assign w_refill   = (state_q == ALLOCATE) & mem_ack_i;
    // A store miss only writes once the refill has made it a hit.
    assign w_word_we  = (w_idle_hit & cpu_we_i) ? (LINE_WORDS'(1) << w_word) : '0;

    assign cpu_data_o  = w_idle_hit ? w_words[w_word] : 32'd0;
    assign cpu_stall_o = cpu_req_i & ~w_idle_hit;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i && !w_hit) begin
                    state_d = (w_valid && w_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {w_vtag, w_idx, {OFFSET_W{1'b0}}};
                mem_data_o = w_line;
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {w_tag, w_idx, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate L1 data-cache controller placed between the pipeline's MEM stage and a slow off-chip data memory. It answers MEM-stage loads and stores in the same cycle on a hit. On a miss it stalls the whole pipeline while it writes back a dirty victim and refills the line over a request/acknowledge memory port.

## Interface
Parameters:
- NUM_LINES, 16, number of cache lines; power of two, ≥2; IDX_W = log2(NUM_LINES)
- LINE_WORDS, 4, 32-bit words per line; fixed at 4, so the line is 128 bits

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-low
- cpu_req_i  in  1  MEM-stage access valid; held stable while cpu_stall_o=1
- cpu_we_i  in  1  1=store, 0=load
- cpu_addr_i  in  32  byte address; bits [1:0] ignored (word-aligned)
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data; valid when cpu_req_i=1 and cpu_stall_o=0
- cpu_stall_o  out  1  freeze PC and all pipeline registers
- mem_req_o  out  1  memory request; level, held until acknowledged
- mem_we_o  out  1  1=line write-back, 0=line fetch
- mem_addr_o  out  32  line-aligned address, bits [3:0]=0
- mem_data_o  out  128  victim line for write-back
- mem_data_i  in  128  refill line; sampled when mem_ack_i=1
- mem_ack_i  in  1  one-cycle completion pulse; ignored while mem_req_o=0

## Operation
- Address split: word = addr[3:2]; index = addr[3+IDX_W:4]; tag = addr[31:4+IDX_W].
- Per line: valid, dirty, tag, 128-bit data.
- hit = cpu_req_i & valid[index] & (tag[index]==tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, load hit: cpu_data_o = selected word, combinational; no state change.
- IDLE, store hit: at the edge, the selected word is replaced by cpu_data_i and dirty is set.
- IDLE, miss: if the victim is valid and dirty, go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK:
  - mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 4'b0}, mem_data_o=victim line.
  - On mem_ack_i, go to ALLOCATE.
- ALLOCATE:
  - mem_req_o=1, mem_we_o=0, mem_addr_o={cpu tag, index, 4'b0}.
  - On mem_ack_i, write mem_data_i into the line, set valid=1, dirty=0, load the tag, and go to IDLE.
- After returning to IDLE, the held access is re-evaluated and hits. A store miss therefore completes as a store hit, leaving the line dirty.
- cpu_stall_o = cpu_req_i & ~(state==IDLE & hit). It is combinational, so a miss stalls in its own cycle.
- Outside WRITEBACK/ALLOCATE: mem_req_o=0, mem_we_o=0, and mem_addr_o/mem_data_o are 0.
- No flush and no invalidate; the memory's line contents are authoritative only for lines that are not dirty.

## Timing
- Reset (rst_i=0), asynchronous:
  - State goes to IDLE; all valid and dirty bits clear.
  - mem_req_o, mem_we_o, mem_addr_o and mem_data_o go to 0 immediately.
  - cpu_data_o=0; cpu_stall_o follows cpu_req_i.
  - Tag and data arrays are not cleared.
- Reset asserted mid-transaction abandons it; mem_req_o falls in the same instant, and the memory must discard the request.
- Hit latency is 0 cycles (combinational).
- Clean miss, memory ack in the Nth ALLOCATE cycle: stall lasts N+1 cycles.
- Dirty miss: stall lasts Nwb + Nrf + 1 cycles.
- mem_ack_i on the cycle the FSM enters a state is legal and counts.
- Back-to-back misses: the second miss is detected in the IDLE cycle after the refill, with no extra bubble.
- cpu_req_i=0 in IDLE: no array update; cpu_stall_o=0.

## Structure
- Package dcache_pkg holds:
  - state enum {IDLE, WRITEBACK, ALLOCATE};
  - localparams LINE_W=128, WORD_SEL_W=2, OFFSET_W=4;
  - tag-width function TAG_W(IDX_W) = 28 − IDX_W.
- One sub-module, dcache_sram: valid, dirty, tag and data arrays.
  - Asynchronous read.
  - Synchronous write with per-word enable and a full-line enable.
  - Asynchronous active-low clear of valid and dirty.
- dcache_ctrl holds the FSM, hit logic, word muxing and the memory-port drive.

## Test plan
- Cold load to 0x0000_0104, memory returns line {D,C,B,A} after 3 cycles:
  - mem_addr_o=0x0000_0100, mem_we_o=0;
  - stall lasts 4 cycles;
  - cpu_data_o=B (word 1);
  - an immediate reload of 0x104 hits with no stall.
- Store 0xDEAD_BEEF to 0x108 after the refill:
  - hit, no stall;
  - a following load of 0x108 returns 0xDEAD_BEEF.
- Load 0x0000_0508 (same index 0, different tag) while the line is dirty:
  - WRITEBACK drives mem_addr_o=0x100, mem_we_o=1, with 0xDEAD_BEEF in word 2 of mem_data_o;
  - then ALLOCATE drives 0x500, mem_we_o=0.
- Store miss to 0x0000_0200 with cpu_data_i=0x1234:
  - refill, then write;
  - the line is dirty and a later load of 0x200 returns 0x1234.
- mem_ack_i pulse in the first WRITEBACK cycle:
  - exactly one write-back, followed by ALLOCATE;
  - a stray mem_ack_i while in IDLE changes nothing.
- rst_i low during ALLOCATE:
  - mem_req_o drops asynchronously;
  - after release, a reload of the same address misses (valid cleared).
